alu_ctrl: RTL and testbench
===========================

Name: alu_ctrl

Overview:
Command-side controller for the 4-bit combinational ALU (a, b, 5-bit f -> y). It accepts user commands over a valid/ready handshake, translates a 3-bit user opcode into the ALU's 5-bit function code, and drives the ALU operand/function ports. It samples the ALU result and returns it over a valid/ready response channel. It also sequences a multi-cycle shift-add multiply using only the ALU's ADD and SHL functions.

Parameters:
MUL_EN, 1, 1 = opcode 110 performs multiply; 0 = opcode 110 is treated as illegal.

Ports:
clk  input  1  single clock; all state changes on the rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE)
cmd_op  input  3  user opcode
cmd_a  input  4  operand A
cmd_b  input  4  operand B
alu_a  output  4  to ALU a
alu_b  output  4  to ALU b
alu_f  output  5  to ALU f
alu_y  input  4  from ALU y (combinational, same cycle)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  4  result
rsp_err  output  1  1 = illegal opcode; rsp_data = 0 in that case
busy  output  1  state != IDLE

Behaviour:
- Opcode map to alu_f:
  - 000 ADD -> 00010
  - 001 SUB -> 00011
  - 010 AND -> 01000
  - 011 OR -> 01100
  - 100 SHR (A>>1, zero fill) -> 00000
  - 101 SHL (A<<1, zero fill) -> 10000
  - 110 MUL (if MUL_EN) -> sequenced
  - 111 -> illegal
- All arithmetic is modulo 16. Carry and borrow are discarded.
- States: IDLE, EXEC, MUL_ADD, MUL_SHL, RESP.
- Reset: state = IDLE; cmd_ready = 1; rsp_valid = 0; rsp_err = 0; rsp_data = 0; busy = 0; alu_a = 0; alu_b = 0; alu_f = 00000; internal regs cleared. Reset wins over every other event, including mid-MUL and a pending response. A response pending at reset is discarded.
- IDLE:
  - alu_a = 0, alu_b = 0, alu_f = 00000.
  - On cmd_valid & cmd_ready: latch op, A, B.
  - Legal non-MUL op -> EXEC.
  - MUL -> MUL_ADD with acc = 0, mcand = A, mplier = B, bit counter = 0.
  - Illegal op -> RESP with rsp_err = 1, rsp_data = 0.
- EXEC (1 cycle):
  - Drive alu_a = A, alu_b = B, alu_f = mapped code.
  - At the next edge: rsp_data <= alu_y, rsp_err <= 0 -> RESP.
  - rsp_valid rises exactly 2 edges after the accepting edge.
- MUL_ADD:
  - Drive alu_a = acc, alu_f = 00010.
  - alu_b = mcand if mplier[cnt] = 1, else 0.
  - At the edge: acc <= alu_y -> MUL_SHL.
- MUL_SHL:
  - Drive alu_a = mcand, alu_b = 0, alu_f = 10000.
  - At the edge: mcand <= alu_y; cnt <= cnt + 1.
  - If cnt was 3: rsp_data <= acc, rsp_err <= 0 -> RESP. Otherwise -> MUL_ADD.
- MUL timing: fixed 8 ALU cycles regardless of operand values. rsp_valid rises 9 edges after the accepting edge. Result = (A*B) mod 16.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_err held stable until rsp_valid & rsp_ready at an edge, then -> IDLE.
  - alu_* return to their IDLE values.
  - cmd_ready = 0 throughout RESP. There is no command/response overlap, so a new command can be accepted at the earliest on the edge after the handshake.
- Outputs are registered or decoded from state only. There are no combinational paths from cmd_* or rsp_ready to any output other than through state.
- cmd_* inputs are ignored when cmd_ready = 0. The latched operands are immune to input changes after acceptance.

Test Plan:
- Reset, then ADD A = 9, B = 8 with rsp_ready = 1 -> rsp_data = 1, rsp_err = 0; rsp_valid high 2 edges after acceptance; alu_f = 00010 during EXEC.
- SUB 3 - 5, then SHR A = 1011, then SHL A = 1011 -> rsp_data = 14, 0101, 0110 respectively; AND 1100 & 1010 = 1000; OR = 1110.
- MUL 7 * 3 -> rsp_data = 5; rsp_valid 9 edges after acceptance; alu_f alternates 00010/10000 four times; with MUL_EN = 0 the same command -> rsp_err = 1, rsp_data = 0.
- Opcode 111 with A = 15, B = 15 -> rsp_err = 1, rsp_data = 0, rsp_valid 1 edge after acceptance; the ALU is never driven with a nonzero f.
- Backpressure: hold rsp_ready = 0 for 5 cycles after an ADD result -> rsp_valid and rsp_data stable, cmd_ready = 0, and a cmd_valid pulse is not accepted; release -> IDLE and cmd_ready = 1 on the next edge.
- Assert rst during MUL_ADD of the 2nd bit -> next edge shows all outputs at reset values and no response is produced; a fresh ADD 2 + 2 then returns 4.

Source files
------------

// File: rtl/alu_ctrl_if.sv
// Command and response handshake bundle between a requester and the alu_ctrl controller.
// The master modport is the requester side; the slave modport is the controller side.
interface alu_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/alu_ctrl.sv
// Command-side controller for a 4-bit combinational ALU: opcode translation, single-cycle ops,
// and a shift-add multiply sequenced through the ALU's ADD and SHL functions.
module alu_ctrl #(
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  alu_ctrl_if.slave        ctrl_if,
  output logic [3:0]       alu_a_o,
  output logic [3:0]       alu_b_o,
  output logic [4:0]       alu_f_o,
  input  logic [3:0]       alu_y_i,
  output logic             busy_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_MUL_ADD = 3'd2,
    S_MUL_SHL = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam logic [4:0] F_ADD = 5'b00010;
  localparam logic [4:0] F_SHL = 5'b10000;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] a_q, a_d;       // operand A; doubles as the shifting multiplicand
  logic [3:0] b_q, b_d;       // operand B; doubles as the multiplier
  logic [3:0] acc_q, acc_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d;

  function automatic logic [4:0] map_op(input logic [2:0] op);
    logic [4:0] f;
    case (op)
      3'b000:  f = 5'b00010;
      3'b001:  f = 5'b00011;
      3'b010:  f = 5'b01000;
      3'b011:  f = 5'b01100;
      3'b100:  f = 5'b00000;
      3'b101:  f = 5'b10000;
      default: f = 5'b00000;
    endcase
    return f;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      a_q        <= 4'd0;
      b_q        <= 4'd0;
      acc_q      <= 4'd0;
      cnt_q      <= 2'd0;
      rsp_data_q <= 4'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (ctrl_if.cmd_valid) begin
          op_d = ctrl_if.cmd_op;
          a_d  = ctrl_if.cmd_a;
          b_d  = ctrl_if.cmd_b;
          if ((ctrl_if.cmd_op == 3'b111) ||
              ((ctrl_if.cmd_op == 3'b110) && (MUL_EN == 1'b0))) begin
            rsp_data_d = 4'd0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end else if (ctrl_if.cmd_op == 3'b110) begin
            acc_d   = 4'd0;
            cnt_d   = 2'd0;
            state_d = S_MUL_ADD;
          end else begin
            state_d = S_EXEC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        rsp_data_d = alu_y_i;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_MUL_ADD: begin
        acc_d   = alu_y_i;
        state_d = S_MUL_SHL;
      end
      S_MUL_SHL: begin
        a_d   = alu_y_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          rsp_data_d = acc_q;
          rsp_err_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          state_d = S_MUL_ADD;
        end
      end
      S_RESP: begin
        if (ctrl_if.rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from state and registers only.
  always_comb begin
    alu_a_o            = 4'd0;
    alu_b_o            = 4'd0;
    alu_f_o            = 5'b00000;
    ctrl_if.cmd_ready  = (state_q == S_IDLE);
    ctrl_if.rsp_valid  = (state_q == S_RESP);
    ctrl_if.rsp_data   = rsp_data_q;
    ctrl_if.rsp_err    = rsp_err_q;
    busy_o             = (state_q != S_IDLE);
    case (state_q)
      S_EXEC: begin
        alu_a_o = a_q;
        alu_b_o = b_q;
        alu_f_o = map_op(op_q);
      end
      S_MUL_ADD: begin
        alu_a_o = acc_q;
        alu_b_o = b_q[cnt_q] ? a_q : 4'd0;
        alu_f_o = F_ADD;
      end
      S_MUL_SHL: begin
        alu_a_o = a_q;
        alu_b_o = 4'd0;
        alu_f_o = F_SHL;
      end
      default: begin
        alu_a_o = 4'd0;
        alu_b_o = 4'd0;
        alu_f_o = 5'b00000;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl: two instances (multiply enabled / disabled) each driving a
// behavioural 4-bit ALU; all expected values are hand-computed constants.
module tb_alu_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_if bus0 ();
  alu_ctrl_if bus1 ();

  logic [3:0] a0, b0, y0, a1, b1, y1;
  logic [4:0] f0, f1;
  logic       busy0, busy1;

  function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [4:0] f);
    logic [3:0] y;
    case (f)
      5'b00010: y = 4'(a + b);
      5'b00011: y = 4'(a - b);
      5'b01000: y = a & b;
      5'b01100: y = a | b;
      5'b00000: y = a >> 1;
      5'b10000: y = a << 1;
      default:  y = 4'd0;
    endcase
    return y;
  endfunction

  assign y0 = alu_model(a0, b0, f0);
  assign y1 = alu_model(a1, b1, f1);

  alu_ctrl #(.MUL_EN(1'b1)) dut0 (
    .clk(clk), .rst(rst), .ctrl_if(bus0.slave),
    .alu_a_o(a0), .alu_b_o(b0), .alu_f_o(f0), .alu_y_i(y0), .busy_o(busy0)
  );

  alu_ctrl #(.MUL_EN(1'b0)) dut1 (
    .clk(clk), .rst(rst), .ctrl_if(bus1.slave),
    .alu_a_o(a1), .alu_b_o(b1), .alu_f_o(f1), .alu_y_i(y1), .busy_o(busy1)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [4:0] flog [16];
  int         nf;

  // Issue one command at a negedge and wait for rsp_valid; edges counts the accepting edge as 1.
  task automatic do_cmd(input bit sel, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, output int edges,
                        output logic [3:0] data, output logic err);
    logic rv;
    if (sel) begin
      bus1.cmd_op = op; bus1.cmd_a = a; bus1.cmd_b = b; bus1.cmd_valid = 1'b1;
    end else begin
      bus0.cmd_op = op; bus0.cmd_a = a; bus0.cmd_b = b; bus0.cmd_valid = 1'b1;
    end
    step();
    bus0.cmd_valid = 1'b0;
    bus1.cmd_valid = 1'b0;
    bus0.cmd_op = 3'd0; bus0.cmd_a = 4'd0; bus0.cmd_b = 4'd0;
    bus1.cmd_op = 3'd0; bus1.cmd_a = 4'd0; bus1.cmd_b = 4'd0;
    edges = 1;
    nf = 0;
    rv = sel ? bus1.rsp_valid : bus0.rsp_valid;
    while (!rv && edges < 40) begin
      if (nf < 16) begin
        flog[nf] = sel ? f1 : f0;
        nf++;
      end
      step();
      edges++;
      rv = sel ? bus1.rsp_valid : bus0.rsp_valid;
    end
    if (!rv) check_eq("rsp_timeout", 32'(rv), 32'd1);
    data = sel ? bus1.rsp_data : bus0.rsp_data;
    err  = sel ? bus1.rsp_err : bus0.rsp_err;
  endtask

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic [4:0] f;
  } vec_t;

  vec_t vecs [6] = '{
    '{3'b000, 4'd9,     4'd8,     4'd1,     5'b00010},
    '{3'b001, 4'd3,     4'd5,     4'd14,    5'b00011},
    '{3'b100, 4'b1011,  4'd0,     4'b0101,  5'b00000},
    '{3'b101, 4'b1011,  4'd0,     4'b0110,  5'b10000},
    '{3'b010, 4'b1100,  4'b1010,  4'b1000,  5'b01000},
    '{3'b011, 4'b1100,  4'b1010,  4'b1110,  5'b01100}
  };

  int         edges;
  logic [3:0] data;
  logic       err;
  logic [4:0] fmax;
  int         spurious;

  initial begin
    bus0.cmd_valid = 1'b0; bus0.cmd_op = 3'd0; bus0.cmd_a = 4'd0; bus0.cmd_b = 4'd0;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'd0; bus1.cmd_a = 4'd0; bus1.cmd_b = 4'd0;
    bus0.rsp_ready = 1'b1;
    bus1.rsp_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    check_eq("rst_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check_eq("rst_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check_eq("rst_rsp_data",  32'(bus0.rsp_data),  32'd0);
    check_eq("rst_rsp_err",   32'(bus0.rsp_err),   32'd0);
    check_eq("rst_busy",      32'(busy0),          32'd0);
    check_eq("rst_alu",       32'({a0, b0, f0}),   32'd0);
    rst = 1'b0;
    step();

    // Single-cycle ops from the table, each answered 2 edges after acceptance.
    for (int i = 0; i < 6; i++) begin
      do_cmd(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, edges, data, err);
      check_eq($sformatf("op%0d_data", i),  32'(data),    32'(vecs[i].y));
      check_eq($sformatf("op%0d_err", i),   32'(err),     32'd0);
      check_eq($sformatf("op%0d_edges", i), 32'(edges),   32'd2);
      check_eq($sformatf("op%0d_f", i),     32'(flog[0]), 32'(vecs[i].f));
      step();
      check_eq($sformatf("op%0d_idle", i), 32'(bus0.cmd_ready), 32'd1);
    end

    // Multiply 7*3 = 21 mod 16 = 5, ADD/SHL alternating four times.
    do_cmd(1'b0, 3'b110, 4'd7, 4'd3, edges, data, err);
    check_eq("mul_data",  32'(data),  32'd5);
    check_eq("mul_err",   32'(err),   32'd0);
    check_eq("mul_edges", 32'(edges), 32'd9);
    check_eq("mul_nf",    32'(nf),    32'd8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("mul_f%0d", i), 32'(flog[i]),
               (i % 2 == 0) ? 32'b00010 : 32'b10000);
    end
    step();

    // Same multiply on the instance without multiply support is illegal.
    do_cmd(1'b1, 3'b110, 4'd7, 4'd3, edges, data, err);
    check_eq("nomul_err",   32'(err),   32'd1);
    check_eq("nomul_data",  32'(data),  32'd0);
    check_eq("nomul_edges", 32'(edges), 32'd1);
    step();

    // Illegal opcode: immediate error response, ALU function never driven.
    fmax = f0;
    do_cmd(1'b0, 3'b111, 4'd15, 4'd15, edges, data, err);
    fmax = fmax | f0;
    check_eq("ill_err",   32'(err),   32'd1);
    check_eq("ill_data",  32'(data),  32'd0);
    check_eq("ill_edges", 32'(edges), 32'd1);
    check_eq("ill_nf",    32'(nf),    32'd0);
    step();
    fmax = fmax | f0;
    check_eq("ill_alu_f", 32'(fmax), 32'd0);

    // Backpressure: response held, a stray command pulse is ignored.
    bus0.rsp_ready = 1'b0;
    do_cmd(1'b0, 3'b000, 4'd4, 4'd5, edges, data, err);
    check_eq("bp_data0", 32'(data), 32'd9);
    for (int i = 0; i < 5; i++) begin
      bus0.cmd_valid = (i == 2);
      bus0.cmd_op    = 3'b001;
      bus0.cmd_a     = 4'd1;
      bus0.cmd_b     = 4'd1;
      step();
      check_eq($sformatf("bp_valid%0d", i), 32'(bus0.rsp_valid), 32'd1);
      check_eq($sformatf("bp_data%0d", i),  32'(bus0.rsp_data),  32'd9);
      check_eq($sformatf("bp_ready%0d", i), 32'(bus0.cmd_ready), 32'd0);
    end
    bus0.cmd_valid = 1'b0;
    bus0.rsp_ready = 1'b1;
    step();
    check_eq("bp_rel_ready", 32'(bus0.cmd_ready), 32'd1);
    check_eq("bp_rel_valid", 32'(bus0.rsp_valid), 32'd0);
    step();
    check_eq("bp_no_accept", 32'(busy0), 32'd0);

    // Reset while the second multiplier bit is being added.
    bus0.cmd_op = 3'b110; bus0.cmd_a = 4'd7; bus0.cmd_b = 4'd3; bus0.cmd_valid = 1'b1;
    step();
    bus0.cmd_valid = 1'b0;
    step();
    step();
    check_eq("mr_f_before", 32'(f0), 32'b00010);
    check_eq("mr_busy_before", 32'(busy0), 32'd1);
    rst = 1'b1;
    step();
    check_eq("mr_cmd_ready", 32'(bus0.cmd_ready), 32'd1);
    check_eq("mr_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    check_eq("mr_rsp",       32'({bus0.rsp_data, bus0.rsp_err}), 32'd0);
    check_eq("mr_busy",      32'(busy0), 32'd0);
    check_eq("mr_alu",       32'({a0, b0, f0}), 32'd0);
    rst = 1'b0;
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus0.rsp_valid || busy0) spurious++;
    end
    check_eq("mr_no_rsp", 32'(spurious), 32'd0);
    do_cmd(1'b0, 3'b000, 4'd2, 4'd2, edges, data, err);
    check_eq("mr_add_data", 32'(data), 32'd4);
    check_eq("mr_add_err",  32'(err),  32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
